// File: rtl/bp_cfg_init_pkg.sv
// Shared definitions for the boot-time config-link init sequencer.
// Optional feature macro: BP_CFG_INIT_NPC_WRITE_EN (adds the per-core npc write).
package bp_cfg_init_pkg;

    // Selectable processor configurations
    typedef enum logic [1:0] {
        e_bp_single_core_cfg = 2'd0,
        e_bp_dual_core_cfg   = 2'd1,
        e_bp_quad_core_cfg   = 2'd2
    } bp_params_e;

    // Subset of the proc-param struct this block consumes
    typedef struct packed {
        logic [7:0] cc_x_dim;
        logic [7:0] cc_y_dim;
        logic [7:0] coh_noc_max_credits;
    } bp_proc_param_s;

    // Config-link register word addresses
    typedef enum logic [2:0] {
        e_cfg_freeze      = 3'd0,
        e_cfg_core_id     = 3'd1,
        e_cfg_icache_mode = 3'd2,
        e_cfg_dcache_mode = 3'd3,
        e_cfg_cce_mode    = 3'd4,
        e_cfg_coh_credits = 3'd5,
        e_cfg_npc         = 3'd6
    } bp_cfg_reg_e;

    localparam int unsigned cfg_reg_idx_width = 3;

`ifdef BP_CFG_INIT_NPC_WRITE_EN
    localparam int unsigned cfg_writes_per_core = 7;
`else
    localparam int unsigned cfg_writes_per_core = 6;
`endif

    // Sequencer FSM states
    localparam logic [2:0] e_reset       = 3'd0;
    localparam logic [2:0] e_send        = 3'd1;
    localparam logic [2:0] e_drain       = 3'd2;
    localparam logic [2:0] e_unfreeze    = 3'd3;
    localparam logic [2:0] e_final_drain = 3'd4;
    localparam logic [2:0] e_done        = 3'd5;

    // Resolve a configuration selector to its parameter set
    function automatic bp_proc_param_s bp_proc_param_lookup(input bp_params_e cfg);
        bp_proc_param_s p;
        p.cc_x_dim            = 8'd1;
        p.cc_y_dim            = 8'd1;
        p.coh_noc_max_credits = 8'd8;
        case (cfg)
            e_bp_dual_core_cfg: p.cc_x_dim = 8'd2;
            e_bp_quad_core_cfg: begin
                p.cc_x_dim = 8'd2;
                p.cc_y_dim = 8'd2;
            end
            default: ;
        endcase
        return p;
    endfunction

    function automatic int unsigned bp_num_core(input bp_params_e cfg);
        bp_proc_param_s p;
        p = bp_proc_param_lookup(cfg);
        return 32'(p.cc_x_dim) * 32'(p.cc_y_dim);
    endfunction

    function automatic int unsigned bp_core_width(input bp_params_e cfg);
        int unsigned n;
        n = bp_num_core(cfg);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/bp_cfg_init_credit_counter.sv
// Outstanding-write credit counter: +1 per transfer, -1 per ack, never wraps below 0.
module bp_cfg_init_credit_counter
#(
    parameter int unsigned max_p   = 4,
    parameter int unsigned width_p = 3
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic up_i,
    input  logic down_i,
    output logic full_o,
    output logic empty_o,
    output logic empty_next_c
);

    logic [width_p-1:0] count_r;
    logic [width_p-1:0] count_n;

    // Next count; simultaneous up and down cancel, ack at zero holds zero
    always_comb begin
        count_n = count_r;
        if (up_i && !down_i) begin
            count_n = count_r + width_p'(1);
        end else if (!up_i && down_i && (count_r != '0)) begin
            count_n = count_r - width_p'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r <= '0;
        end else begin
            count_r <= count_n;
        end
    end

    assign full_o       = (count_r == width_p'(max_p));
    assign empty_o      = (count_r == '0);
    assign empty_next_c = (count_n == '0);

    // An ack with nothing outstanding means the sink is out of step
    ack_at_zero_a: assert property (@(posedge clk_i) disable iff (reset_i)
                                    !(down_i && !up_i && (count_r == '0)))
        else $error("credit counter: ack received with zero outstanding writes");

endmodule

// File: rtl/bp_cfg_init_sequencer.sv
// Boot-time config sequencer: writes each core's config list, drains acks,
// then unfreezes every core and raises done_o.
// Optional feature macro: BP_CFG_INIT_NPC_WRITE_EN (per-core npc write).
module bp_cfg_init_sequencer
    import bp_cfg_init_pkg::*;
#(
    parameter bp_params_e  bp_params_p       = e_bp_single_core_cfg,
    parameter int unsigned cfg_addr_width_p  = 16,
    parameter int unsigned cfg_data_width_p  = 64,
    parameter int unsigned max_outstanding_p = 4,
    parameter logic [63:0] init_npc_p        = 64'h8000_0000
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    output logic                                   cfg_v_o,
    input  logic                                   cfg_ready_i,
    output logic [bp_core_width(bp_params_p)-1:0]  cfg_core_o,
    output logic [cfg_addr_width_p-1:0]            cfg_addr_o,
    output logic [cfg_data_width_p-1:0]            cfg_data_o,
    input  logic                                   cfg_ack_i,
    output logic                                   done_o
);

    localparam bp_proc_param_s proc_param_lp   = bp_proc_param_lookup(bp_params_p);
    localparam int unsigned    num_core_lp     = bp_num_core(bp_params_p);
    localparam int unsigned    core_width_lp   = bp_core_width(bp_params_p);
    localparam int unsigned    credit_width_lp = $clog2(max_outstanding_p + 1);

    localparam logic [cfg_reg_idx_width-1:0] last_reg_lp  = cfg_reg_idx_width'(cfg_writes_per_core - 1);
    localparam logic [core_width_lp-1:0]     last_core_lp = core_width_lp'(num_core_lp - 1);

    logic [2:0]                   state_r;
    logic [2:0]                   state_n;
    logic [cfg_reg_idx_width-1:0] reg_idx_r;
    logic [cfg_reg_idx_width-1:0] reg_idx_n;
    logic [core_width_lp-1:0]     core_idx_r;
    logic [core_width_lp-1:0]     core_idx_n;

    logic issuing;
    logic xfer;
    logic credit_full;
    logic credit_empty;
    logic credit_empty_next;
    logic unused_sigs;

    // Outstanding-write tracking
    bp_cfg_init_credit_counter #(
        .max_p   (max_outstanding_p),
        .width_p (credit_width_lp)
    ) credits (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .up_i         (xfer),
        .down_i       (cfg_ack_i),
        .full_o       (credit_full),
        .empty_o      (credit_empty),
        .empty_next_c (credit_empty_next)
    );

    assign issuing = (state_r == e_send) || (state_r == e_unfreeze);
    assign cfg_v_o = issuing && !credit_full;
    assign xfer    = cfg_v_o && cfg_ready_i;

    // State and index registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= e_reset;
            reg_idx_r  <= '0;
            core_idx_r <= '0;
        end else begin
            state_r    <= state_n;
            reg_idx_r  <= reg_idx_n;
            core_idx_r <= core_idx_n;
        end
    end

    // Next state and index advance; drains are skipped when nothing is outstanding
    always_comb begin
        state_n    = state_r;
        reg_idx_n  = reg_idx_r;
        core_idx_n = core_idx_r;
        case (state_r)
            e_reset: state_n = e_send;
            e_send: begin
                if (xfer) begin
                    if (reg_idx_r == last_reg_lp) begin
                        reg_idx_n = '0;
                        if (core_idx_r == last_core_lp) begin
                            core_idx_n = '0;
                            state_n    = credit_empty_next ? e_unfreeze : e_drain;
                        end else begin
                            core_idx_n = core_idx_r + core_width_lp'(1);
                        end
                    end else begin
                        reg_idx_n = reg_idx_r + cfg_reg_idx_width'(1);
                    end
                end
            end
            e_drain: begin
                if (credit_empty_next) state_n = e_unfreeze;
            end
            e_unfreeze: begin
                if (xfer) begin
                    if (core_idx_r == last_core_lp) begin
                        core_idx_n = '0;
                        state_n    = credit_empty_next ? e_done : e_final_drain;
                    end else begin
                        core_idx_n = core_idx_r + core_width_lp'(1);
                    end
                end
            end
            e_final_drain: begin
                if (credit_empty_next) state_n = e_done;
            end
            e_done:  state_n = e_done;
            default: state_n = e_reset;
        endcase
    end

    // Write payload decode; the unfreeze pass and idle states drive zero data
    always_comb begin
        cfg_data_o = '0;
        if (state_r == e_send) begin
            case (bp_cfg_reg_e'(reg_idx_r))
                e_cfg_freeze, e_cfg_icache_mode,
                e_cfg_dcache_mode, e_cfg_cce_mode:
                    cfg_data_o = cfg_data_width_p'(1);
                e_cfg_core_id:
                    cfg_data_o = cfg_data_width_p'(core_idx_r);
                e_cfg_coh_credits:
                    cfg_data_o = cfg_data_width_p'(proc_param_lp.coh_noc_max_credits);
`ifdef BP_CFG_INIT_NPC_WRITE_EN
                e_cfg_npc:
                    cfg_data_o = cfg_data_width_p'(init_npc_p);
`endif
                default:
                    cfg_data_o = '0;
            endcase
        end
    end

    assign cfg_addr_o = cfg_addr_width_p'(reg_idx_r);
    assign cfg_core_o = core_idx_r;
    assign done_o     = (state_r == e_done);

`ifdef BP_CFG_INIT_NPC_WRITE_EN
    assign unused_sigs = credit_empty;
`else
    assign unused_sigs = ^{credit_empty, init_npc_p};
`endif

endmodule

// File: doc/bp_cfg_init_sequencer.md
# bp_cfg_init_sequencer

Boot-time configuration sequencer that consumes the selected processor configuration (`bp_params_p`) and drives the per-core config-link writes that bring every core tile out of freeze. It sits between reset release and the core tiles' config ports. It emits an ordered write stream with bounded outstanding writes, waits for all acknowledgements, unfreezes every core and raises `done_o`.

## Interface
Parameters:
- `bp_params_p`, default `e_bp_single_core_cfg`: selects the proc-param struct. Core count is `num_core = cc_x_dim * cc_y_dim`.
- `cfg_addr_width_p`, default 16: config-link register address width.
- `cfg_data_width_p`, default 64: config-link data width.
- `max_outstanding_p`, default 4: maximum number of unacknowledged writes in flight; must be ≥1.
- `init_npc_p`, default 64'h8000_0000: boot PC written to each core.

Ports:
- `clk_i` in 1: clock. Single clock domain.
- `reset_i` in 1: synchronous, active-high reset.
- `cfg_v_o` out 1: write valid.
- `cfg_ready_i` in 1: sink ready. A write transfers when `cfg_v_o & cfg_ready_i`.
- `cfg_core_o` out `max(1,clog2(num_core))`: destination core index.
- `cfg_addr_o` out `cfg_addr_width_p`: register address.
- `cfg_data_o` out `cfg_data_width_p`: write data.
- `cfg_ack_i` in 1: one write acknowledged. Acks are pulses and may arrive in any cycle, including the transfer cycle.
- `done_o` out 1: sequence complete. Sticky until reset.

## Operation
- Per-core write list, in order, with word addresses from the shared package:
  - freeze=1 (0x0)
  - core_id=i (0x1)
  - icache_mode=1 (0x2)
  - dcache_mode=1 (0x3)
  - cce_mode=1 (0x4)
  - coh_credits=`coh_noc_max_credits` (0x5)
  - npc=`init_npc_p` (0x6), only when the macro is defined.
- All writes for core 0 go out, then core 1, and so on. After all cores are written and fully acknowledged, a final pass writes freeze=0 (0x0) to cores 0..num_core-1.
- FSM states and transitions:
  - `e_reset`: entered on reset. Goes to `e_send` the cycle after `reset_i` drops.
  - `e_send`: issues the per-core list. After the last transfer, goes to `e_drain`.
  - `e_drain`: waits for outstanding == 0, then goes to `e_unfreeze`.
  - `e_unfreeze`: issues the unfreeze writes. After the last transfer, goes to `e_final_drain`.
  - `e_final_drain`: waits for outstanding == 0, then goes to `e_done`.
  - `e_done`: terminal; stays until reset.
- Credit counter:
  - Width `clog2(max_outstanding_p+1)`.
  - +1 on transfer, −1 on ack. A transfer and an ack in the same cycle leave it unchanged.
  - `cfg_v_o` is forced low when the count equals `max_outstanding_p`.
  - An ack at count 0 is illegal: an assertion fires and the counter stays at 0 (no wrap).
- Index counters:
  - Register index wraps from the last entry to 0 and increments the core index.
  - The core index wraps from num_core-1 to 0 only on the state change.
- Address, data and core outputs are purely a function of the registered state and indices. They stay stable while `cfg_v_o & ~cfg_ready_i`.

## Timing
- Reset values: `cfg_v_o`=0, `done_o`=0, `cfg_core_o`/`cfg_addr_o`/`cfg_data_o`=0, counters=0.
- The first `cfg_v_o` is asserted 1 cycle after `reset_i` deasserts.
- With no backpressure and acks returned in the transfer cycle, the sequence issues one write per cycle with no bubbles, including across core and state boundaries from `e_send` into `e_unfreeze`: the drain state takes 0 extra cycles when outstanding is already 0.
- `done_o` rises the cycle after the last ack is counted.
- Reset asserted mid-sequence: all outputs return to reset values in the next cycle, regardless of in-flight acks. Stale acks after reset are the sink's responsibility.

## Configuration
- `BP_CFG_INIT_NPC_WRITE_EN`
  - Defined: each core receives 7 writes, the last being npc=`init_npc_p`.
  - Undefined: 6 writes per core, no npc write logic, and `init_npc_p` is unused. Cores boot from their hardwired reset PC.

## Structure
- Shared package `bp_cfg_init_pkg` holds:
  - the register address enum (`e_cfg_freeze` … `e_cfg_npc`);
  - the FSM state enum;
  - a per-config constant for writes-per-core.
- One sub-module, `bp_cfg_init_credit_counter`: an up/down counter with `full_o`/`empty_o` and the ack-at-zero assertion.

## Test plan
- **Single-core config, macro on, `cfg_ready_i`=1, ack in the same cycle:** 7+1 = 8 writes at addresses 0,1,2,3,4,5,6,0 with data 1,0,1,1,1,8,0x8000_0000,0 on consecutive cycles. `done_o` is high 9 cycles after reset drops.
- **Dual-core config, macro off:** 2×6+2 = 14 writes. The `cfg_core_o` sequence is 0×6, 1×6, then 0,1. The core_id write to core 1 carries data 1.
- **`max_outstanding_p`=4, acks withheld:** exactly 4 transfers, then `cfg_v_o`=0. A single ack re-enables exactly one more transfer.
- **`cfg_ready_i` low for 5 cycles mid-stream:** `cfg_v_o`, address, data and core hold identical values for all 5 cycles, and no write is skipped or duplicated.
- **Transfer and ack in the same cycle at count 3 (max 4):** the count stays at 3 and the next write issues immediately.
- **Reset asserted after the 3rd transfer:** the next cycle shows `cfg_v_o`=0 and `done_o`=0. After reset is released, the full sequence restarts from core 0, address 0.
